memory_cycle: RTL and testbench

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/memory_cycle_pkg.sv | 30 +++
 rtl/memory_cycle_if.sv | 32 +++
 rtl/memory_cycle_data_memory.sv | 34 +++
 rtl/memory_cycle.sv | 76 +++++++
 tb/tb_memory_cycle.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/memory_cycle_pkg.sv
// Shared pipeline definitions: stage widths, data-memory geometry defaults,
// the misalign mask and the MEM/WB register layout.
package memory_cycle_pkg;

  localparam int XLEN          = 32;
  localparam int REG_IDX_W     = 5;
  localparam int DEPTH_DEFAULT = 1024;
  localparam int AW_DEFAULT    = 10;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef struct packed {
    logic                 reg_write;
    logic                 result_src;
    logic                 misalign;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      pc_plus4;
    logic [XLEN-1:0]      alu_result;
    logic [XLEN-1:0]      read_data;
  } mem_wb_t;

  // Only loads and stores can be misaligned; plain ALU results are never checked.
  function automatic logic is_misaligned(input logic [1:0] byte_off,
                                         input logic       mem_write,
                                         input logic       load);
    return ((byte_off & MISALIGN_MASK) != 2'b00) && (mem_write || load);
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Memory-stage bundle: M-side inputs from execute, W-side outputs to writeback.
// No handshake: every field is valid every cycle and sampled on the rising edge.
interface memory_cycle_if;
  import memory_cycle_pkg::*;

  logic                 RegWriteM;
  logic                 MemWriteM;
  logic                 ResultSrcM;
  logic [REG_IDX_W-1:0] RD_M;
  logic [XLEN-1:0]      PCPlus4M;
  logic [XLEN-1:0]      WriteDataM;
  logic [XLEN-1:0]      ALU_ResultM;

  logic                 RegWriteW;
  logic                 ResultSrcW;
  logic [REG_IDX_W-1:0] RD_W;
  logic [XLEN-1:0]      PCPlus4W;
  logic [XLEN-1:0]      ALU_ResultW;
  logic [XLEN-1:0]      ReadDataW;
  logic                 MisalignW;

  modport master (
    output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
    input  RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, MisalignW
  );

  modport slave (
    input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
    output RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, MisalignW
  );

endinterface

// File: rtl/memory_cycle_data_memory.sv
// Word-organised data memory: combinational read, synchronous write,
// writes blocked while reset is held. Contents survive reset.
module Data_Memory
  import memory_cycle_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WE,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] WD,
  output logic [XLEN-1:0] RD
);

  logic [XLEN-1:0] mem [DEPTH] = '{default: '0};
  logic [AW-1:0]   word_addr;

  // Upper address bits are dropped so byte addresses wrap modulo DEPTH*4.
  assign word_addr = A[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{A[XLEN-1:AW+2], A[1:0]};

  assign RD = mem[word_addr];

  always_ff @(posedge clk) begin
    if (rst && WE) begin
      mem[word_addr] <= WD;
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: data memory access, misalign detection and the
// MEM/WB register. Every W output comes straight from a flop.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic                 ResultSrcM,
  input  logic [REG_IDX_W-1:0] RD_M,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic [XLEN-1:0]      WriteDataM,
  input  logic [XLEN-1:0]      ALU_ResultM,
  output logic                 RegWriteW,
  output logic                 ResultSrcW,
  output logic [REG_IDX_W-1:0] RD_W,
  output logic [XLEN-1:0]      PCPlus4W,
  output logic [XLEN-1:0]      ALU_ResultW,
  output logic [XLEN-1:0]      ReadDataW,
  output logic                 MisalignW
);

  logic            misalign;
  logic            mem_we;
  logic [XLEN-1:0] read_data;
  mem_wb_t         wb_d;
  mem_wb_t         wb_q;

  assign misalign = is_misaligned(ALU_ResultM[1:0], MemWriteM, ResultSrcM);
  assign mem_we   = MemWriteM && !misalign;

  Data_Memory #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_memory (
    .clk (clk),
    .rst (rst),
    .WE  (mem_we),
    .A   (ALU_ResultM),
    .WD  (WriteDataM),
    .RD  (read_data)
  );

  // A misaligned load must not retire into the register file.
  always_comb begin
    wb_d            = '0;
    wb_d.reg_write  = RegWriteM && !(misalign && ResultSrcM);
    wb_d.result_src = ResultSrcM;
    wb_d.misalign   = misalign;
    wb_d.rd         = RD_M;
    wb_d.pc_plus4   = PCPlus4M;
    wb_d.alu_result = ALU_ResultM;
    wb_d.read_data  = read_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign RegWriteW   = wb_q.reg_write;
  assign ResultSrcW  = wb_q.result_src;
  assign MisalignW   = wb_q.misalign;
  assign RD_W        = wb_q.rd;
  assign PCPlus4W    = wb_q.pc_plus4;
  assign ALU_ResultW = wb_q.alu_result;
  assign ReadDataW   = wb_q.read_data;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for the memory stage: inputs change on the falling edge,
// outputs are checked 1 ns after the rising edge against hand-computed values.
module tb_memory_cycle;
  import memory_cycle_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  memory_cycle_if bus ();

  memory_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (bus.RegWriteM),
    .MemWriteM   (bus.MemWriteM),
    .ResultSrcM  (bus.ResultSrcM),
    .RD_M        (bus.RD_M),
    .PCPlus4M    (bus.PCPlus4M),
    .WriteDataM  (bus.WriteDataM),
    .ALU_ResultM (bus.ALU_ResultM),
    .RegWriteW   (bus.RegWriteW),
    .ResultSrcW  (bus.ResultSrcW),
    .RD_W        (bus.RD_W),
    .PCPlus4W    (bus.PCPlus4W),
    .ALU_ResultW (bus.ALU_ResultW),
    .ReadDataW   (bus.ReadDataW),
    .MisalignW   (bus.MisalignW)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive_m(input logic rw, input logic mw, input logic rs,
                         input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] wd, input logic [31:0] alu);
    @(negedge clk);
    bus.RegWriteM   = rw;
    bus.MemWriteM   = mw;
    bus.ResultSrcM  = rs;
    bus.RD_M        = rd;
    bus.PCPlus4M    = pc;
    bus.WriteDataM  = wd;
    bus.ALU_ResultM = alu;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " RegWriteW"},   32'(bus.RegWriteW),  32'h0);
    check({tag, " ResultSrcW"},  32'(bus.ResultSrcW), 32'h0);
    check({tag, " MisalignW"},   32'(bus.MisalignW),  32'h0);
    check({tag, " RD_W"},        32'(bus.RD_W),       32'h0);
    check({tag, " PCPlus4W"},    bus.PCPlus4W,        32'h0);
    check({tag, " ALU_ResultW"}, bus.ALU_ResultW,     32'h0);
    check({tag, " ReadDataW"},   bus.ReadDataW,       32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    bus.RegWriteM   = 1'b0;
    bus.MemWriteM   = 1'b0;
    bus.ResultSrcM  = 1'b0;
    bus.RD_M        = '0;
    bus.PCPlus4M    = '0;
    bus.WriteDataM  = '0;
    bus.ALU_ResultM = '0;

    // Reset held with random inputs: all W outputs stay zero across edges
    drive_m(1'($urandom), 1'b0, 1'($urandom), 5'($urandom), $urandom, $urandom,
            $urandom & 32'hFFFF_F00F);
    step();
    check_all_zero("rst_rand");

    // Store 0xDEADBEEF @0x10 while in reset: must be suppressed
    drive_m(1'b1, 1'b1, 1'b0, 5'd9, 32'h44, 32'hDEAD_BEEF, 32'h10);
    step();
    check_all_zero("rst_store");

    // First edge after release captures normally: load @0x10 reads 0
    drive_m(1'b1, 1'b0, 1'b1, 5'd3, 32'h48, 32'h0, 32'h10);
    rst = 1'b1;
    step();
    check("rel_load ReadDataW", bus.ReadDataW, 32'h0);
    check("rel_load RegWriteW", 32'(bus.RegWriteW), 32'h1);
    check("rel_load RD_W", 32'(bus.RD_W), 32'd3);
    check("rel_load PCPlus4W", bus.PCPlus4W, 32'h48);

    // Store 0x12345678 @0x20, then load it back
    drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'h1234_5678, 32'h20);
    step();
    check("st20 MisalignW", 32'(bus.MisalignW), 32'h0);
    check("st20 ReadDataW_old", bus.ReadDataW, 32'h0);
    drive_m(1'b1, 1'b0, 1'b1, 5'd7, 32'h104, 32'h0, 32'h20);
    step();
    check("ld20 ReadDataW", bus.ReadDataW, 32'h1234_5678);
    check("ld20 RegWriteW", 32'(bus.RegWriteW), 32'h1);
    check("ld20 ResultSrcW", 32'(bus.ResultSrcW), 32'h1);
    check("ld20 RD_W", 32'(bus.RD_W), 32'd7);

    // Address wrap: store @0x1004, load @0x0004
    drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h108, 32'hA5A5_A5A5, 32'h1004);
    step();
    drive_m(1'b1, 1'b0, 1'b1, 5'd8, 32'h10C, 32'h0, 32'h4);
    step();
    check("wrap ReadDataW", bus.ReadDataW, 32'hA5A5_A5A5);
    check("wrap ALU_ResultW", bus.ALU_ResultW, 32'h4);

    // Misaligned store @0x31 flags for one cycle and leaves @0x30 alone
    drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h110, 32'hFFFF_FFFF, 32'h31);
    step();
    check("mis_st MisalignW", 32'(bus.MisalignW), 32'h1);
    drive_m(1'b1, 1'b0, 1'b1, 5'd4, 32'h114, 32'h0, 32'h30);
    step();
    check("ld30 MisalignW", 32'(bus.MisalignW), 32'h0);
    check("ld30 ReadDataW", bus.ReadDataW, 32'h0);
    check("ld30 RegWriteW", 32'(bus.RegWriteW), 32'h1);

    // Misaligned load @0x32 must not write back
    drive_m(1'b1, 1'b0, 1'b1, 5'd6, 32'h118, 32'h0, 32'h32);
    step();
    check("mis_ld RegWriteW", 32'(bus.RegWriteW), 32'h0);
    check("mis_ld MisalignW", 32'(bus.MisalignW), 32'h1);
    check("mis_ld ResultSrcW", 32'(bus.ResultSrcW), 32'h1);

    // Same-cycle read/write @0x40 returns the old word, next read the new one
    drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h11C, 32'h1, 32'h40);
    step();
    drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h120, 32'h2, 32'h40);
    step();
    check("rw40 ReadDataW_old", bus.ReadDataW, 32'h1);
    drive_m(1'b1, 1'b0, 1'b1, 5'd2, 32'h124, 32'h0, 32'h40);
    step();
    check("rd40 ReadDataW_new", bus.ReadDataW, 32'h2);

    // ALU pass-through with low address bits set is not an access
    drive_m(1'b1, 1'b0, 1'b0, 5'd5, 32'h104, 32'h0, 32'h7);
    step();
    check("alu ALU_ResultW", bus.ALU_ResultW, 32'h7);
    check("alu RD_W", 32'(bus.RD_W), 32'd5);
    check("alu PCPlus4W", bus.PCPlus4W, 32'h104);
    check("alu MisalignW", 32'(bus.MisalignW), 32'h0);
    check("alu RegWriteW", 32'(bus.RegWriteW), 32'h1);
    check("alu ResultSrcW", 32'(bus.ResultSrcW), 32'h0);

    // Asynchronous reset clears outputs mid-cycle
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");

    // Store @0x20 while reset spans the edge leaves the word intact
    drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h128, 32'h0000_CAFE, 32'h20);
    step();
    check("rst_st20 ReadDataW", bus.ReadDataW, 32'h0);
    drive_m(1'b1, 1'b0, 1'b1, 5'd1, 32'h12C, 32'h0, 32'h20);
    rst = 1'b1;
    step();
    check("after_rst ld20", bus.ReadDataW, 32'h1234_5678);
    check("after_rst RD_W", 32'(bus.RD_W), 32'd1);

    // Memory contents survive reset: @0x40 still holds 0x2
    drive_m(1'b1, 1'b0, 1'b1, 5'd1, 32'h130, 32'h0, 32'h40);
    step();
    check("after_rst ld40", bus.ReadDataW, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
